npc_fetch_unit: RTL

//  Next-PC generator plus fetch PC register for the pipelined MIPS core.

---
 rtl/npc_fetch_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/npc_fetch_unit.sv
// npc_fetch_unit: next-PC generator and fetch PC register for the pipelined MIPS core.
// Resolves jr/j/conditional branches presented by D, takes exception entry and eret
// redirects, and parks a taken target in pend_q while instruction memory is busy.
// Optional build macro: NPC_ALIGN_CHECK_EN enables the fetch address-error check on
// pc_f (alignment plus IMEM_LO..IMEM_HI window); without it fetch_adel is tied low.
module npc_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(32'h0000_4180),
    parameter logic [PC_W-1:0] IMEM_LO  = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] IMEM_HI  = PC_W'(32'h0000_4ffc)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            br_valid,
    input  logic [3:0]      br_type,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] rt_val,
    input  logic [25:0]     imm26,
    input  logic [PC_W-1:0] pc4_d,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [PC_W-1:0] epc,
    output logic [PC_W-1:0] pc_f,
    output logic [PC_W-1:0] pc4_f,
    output logic            br_taken,
    output logic            hold_o,
    output logic            fetch_adel
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Control-transfer encodings carried on br_type.
    localparam logic [3:0] BT_JR   = 4'd0;
    localparam logic [3:0] BT_J    = 4'd1;
    localparam logic [3:0] BT_BEQ  = 4'd2;
    localparam logic [3:0] BT_BNE  = 4'd3;
    localparam logic [3:0] BT_BLTZ = 4'd4;
    localparam logic [3:0] BT_BLEZ = 4'd5;
    localparam logic [3:0] BT_BGTZ = 4'd6;
    localparam logic [3:0] BT_BGEZ = 4'd7;

    state_t            state;
    logic [PC_W-1:0]   pend_q;

    logic              rs_eq_rt;
    logic              rs_ltz;
    logic              rs_lez;
    logic              d_taken;
    logic [PC_W-1:0]   d_target;

    // Branch outcome from the comparison flags; encodings 8-15 never redirect.
    function automatic logic br_cond(input logic [3:0] t, input logic eq,
                                     input logic ltz, input logic lez);
        logic r;
        r = 1'b0;
        case (t)
            BT_JR:   r = 1'b1;
            BT_J:    r = 1'b1;
            BT_BEQ:  r = eq;
            BT_BNE:  r = ~eq;
            BT_BLTZ: r = ltz;
            BT_BLEZ: r = lez;
            BT_BGTZ: r = ~lez;
            BT_BGEZ: r = ~ltz;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // PC-relative target: word offset sign-extended to PC_W, sum wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] br_target(input logic [PC_W-1:0] base,
                                                   input logic [15:0] off16);
        logic signed [PC_W-1:0] off;
        off = {{(PC_W-18){off16[15]}}, off16, 2'b00};
        return base + $unsigned(off);
    endfunction

    // Pseudo-direct jump target inside the 256 MB region of the delay slot.
    function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] base,
                                                    input logic [25:0] index);
        return {base[PC_W-1:28], index, 2'b00};
    endfunction

    // Decode the instruction in D: signed comparisons and the redirect address.
    always_comb begin
        rs_eq_rt = (rs_val == rt_val);
        rs_ltz   = rs_val[PC_W-1];
        rs_lez   = rs_ltz | (rs_val == '0);
        d_taken  = br_cond(br_type, rs_eq_rt, rs_ltz, rs_lez);
        case (br_type)
            BT_JR:   d_target = rs_val;
            BT_J:    d_target = jump_target(pc4_d, imm26);
            default: d_target = br_target(pc4_d, imm26[15:0]);
        endcase
    end

    // Fetch FSM: redirect priority exc > eret > HOLD drain > D transfer > sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f     <= RESET_PC;
            state    <= ST_RUN;
            pend_q   <= '0;
            br_taken <= 1'b0;
        end else begin
            br_taken <= 1'b0;
            if (exc_req) begin
                pc_f   <= EXC_VEC;
                state  <= ST_RUN;
                pend_q <= '0;
            end else if (eret_req) begin
                pc_f   <= epc;
                state  <= ST_RUN;
                pend_q <= '0;
            end else begin
                case (state)
                    ST_HOLD: begin
                        // A parked target leaves only once imem takes it.
                        if (imem_ready) begin
                            pc_f  <= pend_q;
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        // Under stall D re-presents the branch later, so nothing is consumed.
                        if (!stall) begin
                            if (br_valid && d_taken) begin
                                br_taken <= 1'b1;
                                if (imem_ready) begin
                                    pc_f <= d_target;
                                end else begin
                                    pend_q <= d_target;
                                    state  <= ST_HOLD;
                                end
                            end else if (imem_ready) begin
                                pc_f <= pc_f + PC_W'(4);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign pc4_f  = pc_f + PC_W'(4);
    assign hold_o = (state == ST_HOLD);

`ifdef NPC_ALIGN_CHECK_EN
    // Flag misaligned or out-of-window fetches; the PC still loads the bad value.
    assign fetch_adel = (pc_f[1:0] != 2'b00) | (pc_f < IMEM_LO) | (pc_f > IMEM_HI);
`else
    // Window bounds only matter with the check built in; keep them referenced.
    localparam logic IMEM_RANGE_OK = (IMEM_LO <= IMEM_HI);
    assign fetch_adel = 1'b0 & IMEM_RANGE_OK;
`endif

endmodule
